// File: rtl/ide_sector_fifo.sv
// ide_sector_fifo: word FIFO for an IDE/ATAPI data port. It flags sector
// boundaries in normal mode and packet completion in ATAPI packet mode.
// Pointers carry one extra wrap bit, so level = inptr - outptr modulo 2^(AW+1).
module ide_sector_fifo #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 12,
    parameter int unsigned SW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_en,
    input  logic          flush,
    input  logic [DW-1:0] data_in,
    input  logic          wr,
    input  logic          rd,
    output logic [DW-1:0] data_out,
    input  logic          packet_in,
    input  logic          packet_out,
    input  logic [AW:0]   packet_count,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          sector_ready,
    output logic          packet_in_last,
    output logic          last_in,
    output logic          last_out,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem [Depth];

    logic [AW:0]   inptr_q, outptr_q;
    logic [DW-1:0] data_out_q;
    logic          empty_q;
    logic          overflow_q, underflow_q;

    logic          level_zero;
    logic          wr_ok, rd_ok;
    logic          wr_rej, rd_rej;

    assign level      = inptr_q - outptr_q;
    assign level_zero = (level == '0);
    assign full       = (level == {1'b1, {AW{1'b0}}});

    // The accept/reject decision uses the level before the edge, so at full a
    // read is accepted while a simultaneous write is still rejected.
    assign wr_ok  = clk_en & ~flush & wr & ~full;
    assign rd_ok  = clk_en & ~flush & rd & ~level_zero;
    assign wr_rej = clk_en & ~flush & wr & full;
    assign rd_rej = clk_en & ~flush & rd & level_zero;

    // Pointer, empty-delay and sticky error flag state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inptr_q     <= '0;
            outptr_q    <= '0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                inptr_q     <= '0;
                outptr_q    <= '0;
                empty_q     <= 1'b1;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (wr_ok) inptr_q <= inptr_q + 1'b1;
                if (rd_ok) outptr_q <= outptr_q + 1'b1;
                // Holding empty high for one extra edge covers the RAM write latency
                empty_q <= level_zero;
                if (wr_rej) overflow_q <= 1'b1;
                if (rd_rej) underflow_q <= 1'b1;
            end
        end
    end

    // Storage array write port, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[inptr_q[AW-1:0]] <= data_in;
        end
    end

    // Head-word prefetch; one enabled edge behind outptr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
        end else if (clk_en) begin
            data_out_q <= mem[outptr_q[AW-1:0]];
        end
    end

    // Sector/packet status decoding
    always_comb begin
        sector_ready = 1'b0;
        if (packet_out) begin
            sector_ready = (inptr_q == packet_count);
        end else if (packet_in) begin
            sector_ready = (inptr_q == packet_count) & ~level_zero;
        end else begin
            sector_ready = (inptr_q[AW:SW] != outptr_q[AW:SW]);
        end
    end

    assign packet_in_last = packet_in & (inptr_q == packet_count) & level_zero
                          & (inptr_q != '0);
    assign last_in        = &inptr_q[SW-1:0];
    assign last_out       = &outptr_q[SW-1:0];
    assign empty          = level_zero | empty_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;
    assign data_out       = data_out_q;

endmodule

// File: tb/tb_ide_sector_fifo.sv
// tb_ide_sector_fifo: directed plus randomized stimulus against a queue-based
// reference model of the sector FIFO.
module tb_ide_sector_fifo;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int SW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 1 << (AW + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en, flush, wr, rd;
    logic [DW-1:0] data_in, data_out;
    logic          packet_in, packet_out;
    logic [AW:0]   packet_count, level;
    logic          full, empty, sector_ready, packet_in_last;
    logic          last_in, last_out, overflow, underflow;

    ide_sector_fifo #(.DW(DW), .AW(AW), .SW(SW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_en         (clk_en),
        .flush          (flush),
        .data_in        (data_in),
        .wr             (wr),
        .rd             (rd),
        .data_out       (data_out),
        .packet_in      (packet_in),
        .packet_out     (packet_out),
        .packet_count   (packet_count),
        .level          (level),
        .full           (full),
        .empty          (empty),
        .sector_ready   (sector_ready),
        .packet_in_last (packet_in_last),
        .last_in        (last_in),
        .last_out       (last_out),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, pointers as write/read counts
    logic [DW-1:0] mq[$];
    int            wcnt, rcnt;
    bit            m_ovf, m_unf, m_empd;
    int            checks, failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wcnt   = 0;
        rcnt   = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_empd = 1'b1;
    endtask

    function automatic bit exp_sector_ready();
        if (packet_out) return (wcnt == int'(packet_count));
        if (packet_in) return (wcnt == int'(packet_count)) && (mq.size() != 0);
        return (wcnt / (1 << SW)) != (rcnt / (1 << SW));
    endfunction

    task automatic check_all();
        int n;
        n = mq.size();
        chk("level", 32'(level), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'((n == 0) || m_empd));
        chk("sector_ready", 32'(sector_ready), 32'(exp_sector_ready()));
        chk("packet_in_last", 32'(packet_in_last),
            32'(packet_in && (wcnt == int'(packet_count)) && (n == 0) && (wcnt != 0)));
        chk("last_in", 32'(last_in), 32'((wcnt % (1 << SW)) == (1 << SW) - 1));
        chk("last_out", 32'(last_out), 32'((rcnt % (1 << SW)) == (1 << SW) - 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock with the given inputs, then model update and full check
    task automatic step(input bit en, input bit f, input bit w, input bit r,
                        input logic [DW-1:0] d);
        int            n;
        logic [DW-1:0] popped;
        clk_en  = en;
        flush   = f;
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clk);
        #1;
        if (en) begin
            if (f) begin
                model_reset();
            end else begin
                n      = mq.size();
                m_empd = (n == 0);
                if (r && n == 0) m_unf = 1'b1;
                if (w && n == DEPTH) m_ovf = 1'b1;
                if (r && n > 0) begin
                    popped = mq.pop_front();
                    rcnt   = (rcnt + 1) % PMOD;
                    chk("data_out", 32'(data_out), 32'(popped));
                end
                if (w && n < DEPTH) begin
                    mq.push_back(d);
                    wcnt = (wcnt + 1) % PMOD;
                end
            end
        end
        check_all();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        clk_en       = 1'b0;
        flush        = 1'b0;
        wr           = 1'b0;
        rd           = 1'b0;
        data_in      = '0;
        packet_in    = 1'b0;
        packet_out   = 1'b0;
        packet_count = '0;
        model_reset();

        // Reset state
        #3;
        check_all();
        chk("reset_data_out", 32'(data_out), 32'h0);
        #10;
        reset_n = 1'b1;

        // One full sector in, then out in order
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b1, 1'b0, DW'(i));
        chk("sector_after_256", 32'(sector_ready), 32'h1);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("sector_after_read", 32'(sector_ready), 32'h0);

        // Read on empty with a simultaneous write
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        chk("uf_set", 32'(underflow), 32'h1);
        chk("uf_empty_hold", 32'(empty), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("uf_empty_fall", 32'(empty), 32'h0);

        // Fill to full, overflow, read+write at full, then flush
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("full_level", 32'(level), 32'(DEPTH));
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
        chk("full_overflow", 32'(overflow), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h5678);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h9ABC);
        chk("flush_empty", 32'(empty), 32'h1);

        // Long randomized run with clock-enable gaps; forces pointer wrap
        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 9) != 0), 1'b0,
                 ($urandom_range(0, 99) < ((i < 10000) ? 70 : 45)),
                 ($urandom_range(0, 99) < ((i < 10000) ? 50 : 60)),
                 DW'($urandom));
        end

        // ATAPI packet-in: 6-word packet
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        packet_in    = 1'b1;
        packet_count = (AW + 1)'(6);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("pkt_in_ready", 32'(sector_ready), 32'h1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("pkt_in_done", 32'(sector_ready), 32'h0);
        chk("pkt_in_last", 32'(packet_in_last), 32'h1);

        // ATAPI packet-out: 3-word packet
        packet_in    = 1'b0;
        packet_out   = 1'b1;
        packet_count = (AW + 1)'(3);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("pkt_out_ready", 32'(sector_ready), 32'h1);
        packet_out = 1'b0;

        // Asynchronous reset mid-transfer with the clock enable low
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        clk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_data_out", 32'(data_out), 32'h0);
        #4;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, DW'(16'hA000 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
